rd_circ_buf_datapath: RTL and testbench

Datapath companion to the receive/transmit-buffer read controller. It carries the controller's memory read requests through a 2-entry skid buffer to the memory port and passes read-response handshakes back to the controller. It captures response beats into an upper/lower register pair under controller-issued control strobes. The output is a byte-realigned data word for the consumer, so buffer reads at arbitrary byte offsets and across the circular-buffer wrap produce contiguous, MSB-first output.

---
 rtl/rd_circ_buf_datapath.sv | 152 +++++++++++++++
 tb/tb_rd_circ_buf_datapath.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rd_circ_buf_datapath.sv
// ============================================================================
//  rd_circ_buf_datapath : read-request skid buffer, response pass-through and
//                         upper/lower byte-realignment registers.
//  Revision 1.0
// ============================================================================
`default_nettype none

`ifndef MAC_INTERFACE_W
`define MAC_INTERFACE_W 256
`endif
`ifndef MAC_INTERFACE_BYTES_W
`define MAC_INTERFACE_BYTES_W 5
`endif

package rd_circ_buf_pkg;
   localparam int MEM_ADDR_W = 64;
   localparam int MEM_SIZE_W = 16;

   typedef struct packed {
      logic [MEM_ADDR_W-1:0] mem_req_addr;
      logic [MEM_SIZE_W-1:0] mem_req_size;
   } mem_req_struct;
endpackage

module rd_circ_buf_datapath
   import rd_circ_buf_pkg::*;
#(
   parameter int DATA_W       = `MAC_INTERFACE_W,
   parameter int DATA_BYTES_W = `MAC_INTERFACE_BYTES_W
) (
   input  logic                    clk,
   input  logic                    rst,

   input  logic                    ctrl_datapath_rd_req_val,
   input  mem_req_struct           ctrl_datapath_rd_req_data,
   output logic                    datapath_ctrl_rd_req_rdy,

   output logic                    datapath_mem_rd_req_val,
   output mem_req_struct           datapath_mem_rd_req_data,
   input  logic                    mem_datapath_rd_req_rdy,

   input  logic                    mem_datapath_resp_data_val,
   input  logic [DATA_W-1:0]       mem_datapath_resp_data,
   input  logic                    mem_datapath_resp_data_last,
   input  logic [DATA_BYTES_W:0]   mem_datapath_resp_data_padbytes,
   output logic                    datapath_mem_resp_data_rdy,

   output logic                    datapath_ctrl_resp_data_val,
   output logic                    datapath_ctrl_resp_data_last,
   output logic [DATA_BYTES_W:0]   datapath_ctrl_resp_data_padbytes,
   input  logic                    ctrl_datapath_resp_data_rdy,

   input  logic [DATA_BYTES_W-1:0] mem_data_shift_bytes,
   input  logic                    write_upper,
   input  logic                    shift_upper,
   input  logic                    shift_lower,
   input  logic                    shift_lower_zeros,
   input  logic [DATA_BYTES_W:0]   rd_buf_src_data_padbytes,
   output logic [DATA_W-1:0]       rd_buf_src_data
);

   localparam int C_NUM_BYTES = DATA_W / 8;

   // ------------------------------------------------------------------------
   // Request skid buffer: entry 0 is always the head.
   // ------------------------------------------------------------------------
   logic [1:0]    r_cnt;
   mem_req_struct r_entry0;
   mem_req_struct r_entry1;
   logic          w_push;
   logic          w_pop;

   assign datapath_ctrl_rd_req_rdy = (r_cnt != 2'd2);
   assign datapath_mem_rd_req_val  = (r_cnt != 2'd0);
   assign datapath_mem_rd_req_data = r_entry0;

   assign w_push = ctrl_datapath_rd_req_val & datapath_ctrl_rd_req_rdy;
   assign w_pop  = datapath_mem_rd_req_val & mem_datapath_rd_req_rdy;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt    <= 2'd0;
         r_entry0 <= '0;
         r_entry1 <= '0;
      end else begin
         case ({w_push, w_pop})
            2'b10: begin
               if (r_cnt == 2'd0) r_entry0 <= ctrl_datapath_rd_req_data;
               else               r_entry1 <= ctrl_datapath_rd_req_data;
               r_cnt <= r_cnt + 2'd1;
            end
            2'b01: begin
               r_entry0 <= r_entry1;
               r_cnt    <= r_cnt - 2'd1;
            end
            2'b11: begin
               // Push while full cannot happen, so cnt is 1 here: new entry is head.
               r_entry0 <= ctrl_datapath_rd_req_data;
            end
            default: ;
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Response handshake pass-through
   // ------------------------------------------------------------------------
   assign datapath_ctrl_resp_data_val      = mem_datapath_resp_data_val;
   assign datapath_ctrl_resp_data_last     = mem_datapath_resp_data_last;
   assign datapath_ctrl_resp_data_padbytes = mem_datapath_resp_data_padbytes;
   assign datapath_mem_resp_data_rdy       = ctrl_datapath_resp_data_rdy;

   // ------------------------------------------------------------------------
   // Upper/lower capture registers
   // ------------------------------------------------------------------------
   logic [DATA_W-1:0] r_upper;
   logic [DATA_W-1:0] r_lower;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_upper <= '0;
         r_lower <= '0;
      end else begin
         if (write_upper)      r_upper <= mem_datapath_resp_data;
         else if (shift_upper) r_upper <= r_lower;

         if (shift_lower_zeros) r_lower <= '0;
         else if (shift_lower)  r_lower <= mem_datapath_resp_data;
      end
   end

   // ------------------------------------------------------------------------
   // Byte realignment and trailing-pad masking (byte 0 is the MSB byte)
   // ------------------------------------------------------------------------
   logic [2*DATA_W-1:0] w_cat_shifted;
   logic [DATA_W-1:0]   w_window;
   logic [DATA_W-1:0]   w_mask;

   assign w_cat_shifted = {r_upper, r_lower} << {mem_data_shift_bytes, 3'b000};
   assign w_window      = w_cat_shifted[2*DATA_W-1 -: DATA_W];

   always_comb begin
      w_mask = '1;
      if (int'(rd_buf_src_data_padbytes) >= C_NUM_BYTES) w_mask = '0;
      else w_mask = {DATA_W{1'b1}} << {rd_buf_src_data_padbytes, 3'b000};
   end

   assign rd_buf_src_data = w_window & w_mask;

endmodule

`default_nettype wire

// File: tb/tb_rd_circ_buf_datapath.sv
// Directed self-checking bench for rd_circ_buf_datapath (DATA_W = 256).
`default_nettype none

module tb_rd_circ_buf_datapath;
   import rd_circ_buf_pkg::*;

   localparam int DW = 256;
   localparam int BW = 5;

   logic clk = 1'b0;
   logic rst;
   logic ctrl_datapath_rd_req_val;
   mem_req_struct ctrl_datapath_rd_req_data;
   logic datapath_ctrl_rd_req_rdy;
   logic datapath_mem_rd_req_val;
   mem_req_struct datapath_mem_rd_req_data;
   logic mem_datapath_rd_req_rdy;
   logic mem_datapath_resp_data_val;
   logic [DW-1:0] mem_datapath_resp_data;
   logic mem_datapath_resp_data_last;
   logic [BW:0] mem_datapath_resp_data_padbytes;
   logic datapath_mem_resp_data_rdy;
   logic datapath_ctrl_resp_data_val;
   logic datapath_ctrl_resp_data_last;
   logic [BW:0] datapath_ctrl_resp_data_padbytes;
   logic ctrl_datapath_resp_data_rdy;
   logic [BW-1:0] mem_data_shift_bytes;
   logic write_upper, shift_upper, shift_lower, shift_lower_zeros;
   logic [BW:0] rd_buf_src_data_padbytes;
   logic [DW-1:0] rd_buf_src_data;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   rd_circ_buf_datapath #(.DATA_W(DW), .DATA_BYTES_W(BW)) dut (
      .clk                              (clk),
      .rst                              (rst),
      .ctrl_datapath_rd_req_val         (ctrl_datapath_rd_req_val),
      .ctrl_datapath_rd_req_data        (ctrl_datapath_rd_req_data),
      .datapath_ctrl_rd_req_rdy         (datapath_ctrl_rd_req_rdy),
      .datapath_mem_rd_req_val          (datapath_mem_rd_req_val),
      .datapath_mem_rd_req_data         (datapath_mem_rd_req_data),
      .mem_datapath_rd_req_rdy          (mem_datapath_rd_req_rdy),
      .mem_datapath_resp_data_val       (mem_datapath_resp_data_val),
      .mem_datapath_resp_data           (mem_datapath_resp_data),
      .mem_datapath_resp_data_last      (mem_datapath_resp_data_last),
      .mem_datapath_resp_data_padbytes  (mem_datapath_resp_data_padbytes),
      .datapath_mem_resp_data_rdy       (datapath_mem_resp_data_rdy),
      .datapath_ctrl_resp_data_val      (datapath_ctrl_resp_data_val),
      .datapath_ctrl_resp_data_last     (datapath_ctrl_resp_data_last),
      .datapath_ctrl_resp_data_padbytes (datapath_ctrl_resp_data_padbytes),
      .ctrl_datapath_resp_data_rdy      (ctrl_datapath_resp_data_rdy),
      .mem_data_shift_bytes             (mem_data_shift_bytes),
      .write_upper                      (write_upper),
      .shift_upper                      (shift_upper),
      .shift_lower                      (shift_lower),
      .shift_lower_zeros                (shift_lower_zeros),
      .rd_buf_src_data_padbytes         (rd_buf_src_data_padbytes),
      .rd_buf_src_data                  (rd_buf_src_data)
   );

   // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic strobes(input logic wu, input logic su, input logic sl, input logic slz);
      write_upper = wu; shift_upper = su; shift_lower = sl; shift_lower_zeros = slz;
   endtask

   function automatic mem_req_struct mk_req(input logic [63:0] addr, input logic [15:0] size);
      mem_req_struct r;
      r.mem_req_addr = addr;
      r.mem_req_size = size;
      return r;
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      tick();
      #1;
      checks++;
      if (datapath_ctrl_rd_req_rdy !== 1'b1 || datapath_mem_rd_req_val !== 1'b0) begin
         errors++;
         $display("FAIL reset_during: rdy=%b val=%b required rdy=1 val=0",
                  datapath_ctrl_rd_req_rdy, datapath_mem_rd_req_val);
      end
      tick();
      rst = 1'b0;
      tick();
      #1;
      checks++;
      if (datapath_ctrl_rd_req_rdy !== 1'b1) begin
         errors++; $display("FAIL reset_rdy: got %b required 1", datapath_ctrl_rd_req_rdy);
      end
      checks++;
      if (datapath_mem_rd_req_val !== 1'b0) begin
         errors++; $display("FAIL reset_val: got %b required 0", datapath_mem_rd_req_val);
      end
      checks++;
      if (rd_buf_src_data !== '0) begin
         errors++; $display("FAIL reset_out: got %h required 0", rd_buf_src_data);
      end
   endtask

   task automatic test_request_fifo();
      mem_datapath_rd_req_rdy = 1'b0;
      ctrl_datapath_rd_req_val = 1'b1;
      ctrl_datapath_rd_req_data = mk_req(64'h100, 16'd64);
      tick();
      ctrl_datapath_rd_req_data = mk_req(64'h120, 16'd32);
      tick();
      ctrl_datapath_rd_req_data = mk_req(64'h140, 16'd16);
      #1;
      checks++;
      if (datapath_ctrl_rd_req_rdy !== 1'b0) begin
         errors++; $display("FAIL fifo_full_rdy: got %b required 0", datapath_ctrl_rd_req_rdy);
      end
      tick();
      ctrl_datapath_rd_req_val = 1'b0;
      mem_datapath_rd_req_rdy = 1'b1;
      #1;
      checks++;
      if (datapath_mem_rd_req_val !== 1'b1 || datapath_mem_rd_req_data.mem_req_addr !== 64'h100
          || datapath_mem_rd_req_data.mem_req_size !== 16'd64) begin
         errors++;
         $display("FAIL fifo_head0: val=%b addr=%h size=%0d required val=1 addr=100 size=64",
                  datapath_mem_rd_req_val, datapath_mem_rd_req_data.mem_req_addr,
                  datapath_mem_rd_req_data.mem_req_size);
      end
      tick();
      #1;
      checks++;
      if (datapath_mem_rd_req_val !== 1'b1 || datapath_mem_rd_req_data.mem_req_addr !== 64'h120) begin
         errors++;
         $display("FAIL fifo_head1: val=%b addr=%h required val=1 addr=120",
                  datapath_mem_rd_req_val, datapath_mem_rd_req_data.mem_req_addr);
      end
      checks++;
      if (datapath_ctrl_rd_req_rdy !== 1'b1) begin
         errors++; $display("FAIL fifo_rdy_back: got %b required 1", datapath_ctrl_rd_req_rdy);
      end
      tick();
      #1;
      checks++;
      if (datapath_mem_rd_req_val !== 1'b0) begin
         errors++; $display("FAIL fifo_empty: val=%b required 0 (blocked push leaked?)",
                            datapath_mem_rd_req_val);
      end
   endtask

   task automatic test_back_to_back();
      mem_datapath_rd_req_rdy = 1'b1;
      ctrl_datapath_rd_req_val = 1'b1;
      ctrl_datapath_rd_req_data = mk_req(64'h200, 16'd8);
      tick();
      ctrl_datapath_rd_req_data = mk_req(64'h220, 16'd9);
      #1;
      checks++;
      if (datapath_mem_rd_req_val !== 1'b1 || datapath_mem_rd_req_data.mem_req_addr !== 64'h200) begin
         errors++; $display("FAIL b2b_first: val=%b addr=%h required val=1 addr=200",
                            datapath_mem_rd_req_val, datapath_mem_rd_req_data.mem_req_addr);
      end
      tick();
      ctrl_datapath_rd_req_val = 1'b0;
      #1;
      checks++;
      if (datapath_mem_rd_req_val !== 1'b1 || datapath_mem_rd_req_data.mem_req_addr !== 64'h220
          || datapath_mem_rd_req_data.mem_req_size !== 16'd9) begin
         errors++; $display("FAIL b2b_second: val=%b addr=%h required val=1 addr=220",
                            datapath_mem_rd_req_val, datapath_mem_rd_req_data.mem_req_addr);
      end
      tick();
      #1;
      checks++;
      if (datapath_mem_rd_req_val !== 1'b0 || datapath_ctrl_rd_req_rdy !== 1'b1) begin
         errors++; $display("FAIL b2b_drain: val=%b rdy=%b required val=0 rdy=1",
                            datapath_mem_rd_req_val, datapath_ctrl_rd_req_rdy);
      end
   endtask

   task automatic test_passthrough();
      mem_datapath_resp_data_val = 1'b1;
      mem_datapath_resp_data_last = 1'b1;
      mem_datapath_resp_data_padbytes = 6'd13;
      ctrl_datapath_resp_data_rdy = 1'b1;
      #1;
      checks++;
      if (datapath_ctrl_resp_data_val !== 1'b1 || datapath_ctrl_resp_data_last !== 1'b1
          || datapath_ctrl_resp_data_padbytes !== 6'd13 || datapath_mem_resp_data_rdy !== 1'b1) begin
         errors++; $display("FAIL pass_on: val=%b last=%b pad=%0d rdy=%b required 1 1 13 1",
                            datapath_ctrl_resp_data_val, datapath_ctrl_resp_data_last,
                            datapath_ctrl_resp_data_padbytes, datapath_mem_resp_data_rdy);
      end
      mem_datapath_resp_data_val = 1'b0;
      mem_datapath_resp_data_last = 1'b0;
      mem_datapath_resp_data_padbytes = 6'd2;
      ctrl_datapath_resp_data_rdy = 1'b0;
      #1;
      checks++;
      if (datapath_ctrl_resp_data_val !== 1'b0 || datapath_ctrl_resp_data_last !== 1'b0
          || datapath_ctrl_resp_data_padbytes !== 6'd2 || datapath_mem_resp_data_rdy !== 1'b0) begin
         errors++; $display("FAIL pass_off: val=%b last=%b pad=%0d rdy=%b required 0 0 2 0",
                            datapath_ctrl_resp_data_val, datapath_ctrl_resp_data_last,
                            datapath_ctrl_resp_data_padbytes, datapath_mem_resp_data_rdy);
      end
   endtask

   task automatic test_aligned();
      logic [DW-1:0] a;
      a = {8{32'hA1B2C3D4}} ^ {32'h01020304, 224'h0};
      mem_data_shift_bytes = '0;
      rd_buf_src_data_padbytes = '0;
      mem_datapath_resp_data = a;
      strobes(1'b1, 1'b0, 1'b0, 1'b1);
      tick();
      strobes(1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      checks++;
      if (rd_buf_src_data !== a) begin
         errors++; $display("FAIL aligned_A: got %h required %h", rd_buf_src_data, a);
      end
      strobes(1'b0, 1'b1, 1'b0, 1'b1);
      tick();
      strobes(1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      checks++;
      if (rd_buf_src_data !== '0) begin
         errors++; $display("FAIL aligned_zero: got %h required 0", rd_buf_src_data);
      end
   endtask

   task automatic test_unaligned();
      logic [DW-1:0] a, b, exp;
      for (int i = 0; i < 32; i++) begin
         a[DW-1-8*i -: 8] = 8'(8'h10 + i);
         b[DW-1-8*i -: 8] = 8'(8'h80 + i);
      end
      // A bytes 5..31 followed by B bytes 0..4
      exp = {a[215:0], b[255:216]};
      mem_data_shift_bytes = 5'd5;
      rd_buf_src_data_padbytes = '0;
      mem_datapath_resp_data = a;
      strobes(1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      mem_datapath_resp_data = b;
      strobes(1'b0, 1'b1, 1'b1, 1'b0);
      tick();
      strobes(1'b0, 1'b0, 1'b0, 1'b0);
      mem_datapath_resp_data = '0;
      #1;
      checks++;
      if (rd_buf_src_data !== exp) begin
         errors++; $display("FAIL unaligned_5: got %h required %h", rd_buf_src_data, exp);
      end
      mem_data_shift_bytes = 5'd31;
      exp = {a[7:0], b[255:8]};
      #1;
      checks++;
      if (rd_buf_src_data !== exp) begin
         errors++; $display("FAIL unaligned_31: got %h required %h", rd_buf_src_data, exp);
      end
   endtask

   task automatic test_pad_masking();
      logic [DW-1:0] exp;
      mem_data_shift_bytes = '0;
      rd_buf_src_data_padbytes = '0;
      mem_datapath_resp_data = '1;
      strobes(1'b1, 1'b0, 1'b0, 1'b1);
      tick();
      strobes(1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      checks++;
      if (rd_buf_src_data !== {DW{1'b1}}) begin
         errors++; $display("FAIL pad_0: got %h required all ff", rd_buf_src_data);
      end
      rd_buf_src_data_padbytes = 6'd7;
      exp = {{25{8'hFF}}, {7{8'h00}}};
      #1;
      checks++;
      if (rd_buf_src_data !== exp) begin
         errors++; $display("FAIL pad_7: got %h required %h", rd_buf_src_data, exp);
      end
      rd_buf_src_data_padbytes = 6'd31;
      exp = {8'hFF, {31{8'h00}}};
      #1;
      checks++;
      if (rd_buf_src_data !== exp) begin
         errors++; $display("FAIL pad_31: got %h required %h", rd_buf_src_data, exp);
      end
      rd_buf_src_data_padbytes = 6'd32;
      #1;
      checks++;
      if (rd_buf_src_data !== '0) begin
         errors++; $display("FAIL pad_32: got %h required 0", rd_buf_src_data);
      end
      rd_buf_src_data_padbytes = '0;
   endtask

   task automatic test_priority();
      logic [DW-1:0] c, d, e, exp;
      d = {16{16'hD00D}};
      e = {16{16'hE11E}};
      c = {16{16'hC33C}} ^ {64'h0123456789ABCDEF, 192'h0};
      mem_data_shift_bytes = '0;
      rd_buf_src_data_padbytes = '0;
      mem_datapath_resp_data = d;
      strobes(1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      mem_datapath_resp_data = e;
      strobes(1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      mem_datapath_resp_data = c;
      strobes(1'b1, 1'b1, 1'b1, 1'b1);
      tick();
      strobes(1'b0, 1'b0, 1'b0, 1'b0);
      mem_datapath_resp_data = '0;
      #1;
      checks++;
      if (rd_buf_src_data !== c) begin
         errors++; $display("FAIL prio_upper: got %h required %h", rd_buf_src_data, c);
      end
      mem_data_shift_bytes = 5'd16;
      exp = {c[127:0], 128'h0};
      #1;
      checks++;
      if (rd_buf_src_data !== exp) begin
         errors++; $display("FAIL prio_lower: got %h required %h", rd_buf_src_data, exp);
      end
      mem_data_shift_bytes = '0;
   endtask

   task automatic test_reset_mid();
      mem_datapath_rd_req_rdy = 1'b0;
      ctrl_datapath_rd_req_val = 1'b1;
      ctrl_datapath_rd_req_data = mk_req(64'h300, 16'd1);
      mem_datapath_resp_data = {32{8'h5A}};
      strobes(1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      ctrl_datapath_rd_req_data = mk_req(64'h320, 16'd2);
      strobes(1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      ctrl_datapath_rd_req_val = 1'b0;
      #1;
      checks++;
      if (datapath_mem_rd_req_val !== 1'b1 || datapath_ctrl_rd_req_rdy !== 1'b0
          || rd_buf_src_data !== {32{8'h5A}}) begin
         errors++; $display("FAIL mid_pre: val=%b rdy=%b out=%h required val=1 rdy=0 out=5a..",
                            datapath_mem_rd_req_val, datapath_ctrl_rd_req_rdy, rd_buf_src_data);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      checks++;
      if (datapath_mem_rd_req_val !== 1'b0 || datapath_ctrl_rd_req_rdy !== 1'b1) begin
         errors++; $display("FAIL mid_fifo: val=%b rdy=%b required val=0 rdy=1",
                            datapath_mem_rd_req_val, datapath_ctrl_rd_req_rdy);
      end
      mem_data_shift_bytes = 5'd16;
      #1;
      checks++;
      if (rd_buf_src_data !== '0) begin
         errors++; $display("FAIL mid_regs: got %h required 0", rd_buf_src_data);
      end
      mem_data_shift_bytes = '0;
   endtask

   initial begin
      rst = 1'b1;
      ctrl_datapath_rd_req_val = 1'b0;
      ctrl_datapath_rd_req_data = '0;
      mem_datapath_rd_req_rdy = 1'b0;
      mem_datapath_resp_data_val = 1'b0;
      mem_datapath_resp_data = '0;
      mem_datapath_resp_data_last = 1'b0;
      mem_datapath_resp_data_padbytes = '0;
      ctrl_datapath_resp_data_rdy = 1'b0;
      mem_data_shift_bytes = '0;
      rd_buf_src_data_padbytes = '0;
      strobes(1'b0, 1'b0, 1'b0, 1'b0);

      test_reset();
      test_request_fifo();
      test_back_to_back();
      test_passthrough();
      test_aligned();
      test_unaligned();
      test_pad_masking();
      test_priority();
      test_reset_mid();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
